// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, presents it to the icache, and buffers
// returned instructions with their PCs in a small prefetch FIFO that drains
// to the instruction queue over valid/ready. Prioritised redirect channels
// retarget the PC and flush the FIFO.
// Optional feature macro: FETCH_PERF_EN (adds fetch/redirect/stall counters).
module fetch_unit #(
  parameter int ADDR_WIDTH   = 32,
  parameter int INST_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int NUM_REDIRECT = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                           clk_in,
  input  logic                           rst_n_in,
  input  logic                           rdy_in,
  input  logic                           icache_if_miss_in,
  input  logic [INST_WIDTH-1:0]          icache_if_inst_inst_in,
  output logic [ADDR_WIDTH-1:0]          if_icache_inst_addr_out,
  input  logic [NUM_REDIRECT-1:0]        redirect_en_in,
  input  logic [NUM_REDIRECT*ADDR_WIDTH-1:0] redirect_pc_in,
  output logic                           if_instqueue_en_out,
  output logic [INST_WIDTH-1:0]          if_instqueue_inst_out,
  output logic [ADDR_WIDTH-1:0]          if_instqueue_pc_out,
  input  logic                           instqueue_if_rdy_in
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                    perf_fetch_cnt_out,
  output logic [31:0]                    perf_redirect_cnt_out,
  output logic [31:0]                    perf_stall_cnt_out
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [INST_WIDTH-1:0] inst;
  } entry_t;

  entry_t [FIFO_DEPTH-1:0] fifo_q;
  logic [PTR_W-1:0]        head_q, tail_q;
  logic [PTR_W:0]          count_q;
  logic [ADDR_WIDTH-1:0]   pc_q;

  logic                    redir_any, pop, push;
  logic [ADDR_WIDTH-1:0]   redir_tgt;

  // Pick the lowest-index asserted redirect channel; scanning downward lets
  // lower indices overwrite higher ones.
  always_comb begin
    redir_tgt = '0;
    for (int i = NUM_REDIRECT-1; i >= 0; i--)
      if (redirect_en_in[i]) redir_tgt = redirect_pc_in[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign redir_any = |redirect_en_in;
  assign pop  = rdy_in && (count_q != '0) && instqueue_if_rdy_in;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign push = rdy_in && !redir_any && !icache_if_miss_in &&
                ((count_q < DEPTH_C) || pop);

  // PC, FIFO storage, pointers and occupancy; redirect overrides push/pop.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pc_q    <= RESET_PC;
      fifo_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy_in) begin
      if (redir_any) begin
        pc_q    <= redir_tgt;
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
      end else begin
        if (push) begin
          fifo_q[tail_q] <= '{pc: pc_q, inst: icache_if_inst_inst_in};
          tail_q         <= tail_q + PTR_W'(1);
          pc_q           <= pc_q + ADDR_WIDTH'(4);
        end
        if (pop) head_q <= head_q + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (PTR_W+1)'(1);
          2'b01:   count_q <= count_q - (PTR_W+1)'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign if_icache_inst_addr_out = pc_q;
  assign if_instqueue_en_out     = (count_q != '0);
  assign if_instqueue_inst_out   = fifo_q[head_q].inst;
  assign if_instqueue_pc_out     = fifo_q[head_q].pc;

`ifdef FETCH_PERF_EN
  // Event counters; they freeze with the rest of the stage when rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      perf_fetch_cnt_out    <= '0;
      perf_redirect_cnt_out <= '0;
      perf_stall_cnt_out    <= '0;
    end else if (rdy_in) begin
      if (push)                          perf_fetch_cnt_out    <= perf_fetch_cnt_out + 32'd1;
      if (redir_any)                     perf_redirect_cnt_out <= perf_redirect_cnt_out + 32'd1;
      if (icache_if_miss_in && !redir_any) perf_stall_cnt_out  <= perf_stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule
